nan_pixel_deser: RTL and testbench
==================================

# nan_pixel_deser

Serial-to-pixel deserializer directly downstream of the NanEye Manchester bit decoder. Consumes the decoded bit stream (S_DATA qualified by S_WREN) and the continuous-zero indicator CON_ZERO. Frames 12-bit sensor words into 10-bit pixels, checks start/stop bits, and tracks column and row position. Emits pixel-valid strobes with line and frame markers for the line buffer / FIFO writer.

## Interface
- WORD_W, 12: serial word length: start bit, pixel bits, stop bit.
- PIX_W, 10: pixel width. Must equal WORD_W-2.
- COLS, 250: pixels per row.
- ROWS, 250: rows per frame.
- ERR_W, 8: width of the word-error counter.

Ports (reset RESET, asynchronous, active-low; clock SCLOCK):
- SCLOCK  in  1  sampling clock, same domain as the decoder.
- RESET  in  1  asynchronous active-low reset.
- S_DATA  in  1  decoded bit, valid only when S_WREN=1.
- S_WREN  in  1  one-cycle bit strobe from the decoder.
- CON_ZERO  in  1  high during sync/idle gaps. Falling edge = frame data begins.
- PIX_DATA  out  PIX_W  assembled pixel, MSB first on the wire.
- PIX_VALID  out  1  one-cycle pixel strobe.
- PIX_SOL  out  1  with PIX_VALID: column 0.
- PIX_EOL  out  1  with PIX_VALID: column COLS-1.
- PIX_SOF  out  1  with PIX_VALID: row 0, column 0.
- PIX_EOF  out  1  with PIX_VALID: row ROWS-1, column COLS-1.
- WORD_ERR  out  1  with PIX_VALID: start bit ≠1 or stop bit ≠0.
- FRAME_SHORT  out  1  one-cycle pulse: CON_ZERO rose before the frame completed.
- ERR_CNT  out  ERR_W  saturating count of WORD_ERR in the current frame.

## Operation
- All outputs reset to 0.
- CON_ZERO is registered once internally (cz_d). Rise and fall are detected from CON_ZERO versus cz_d.
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
  - IDLE -> SHIFT on a CON_ZERO fall. On entry, clear the bit counter, column, row and ERR_CNT.
  - SHIFT: each S_WREN=1 shifts S_DATA into a WORD_W shift register, LSB side in; the first-received bit ends at the MSB. The bit counter runs 0..WORD_W-1.
    - When the bit counter is WORD_W-1 and S_WREN=1, the word is complete and the bit counter wraps to 0.
    - Bit[WORD_W-1] is the start bit, bits[WORD_W-2:1] are the pixel, bit[0] is the stop bit.
    - A completed word issues PIX_VALID and the flags, then advances the column. At column COLS-1 the column wraps to 0 and the row increments.
    - The word that produces PIX_EOF moves the FSM to DONE.
  - SHIFT, CON_ZERO rises: pulse FRAME_SHORT and go to IDLE. The partial word is discarded and no PIX_VALID is issued.
  - SHIFT, CON_ZERO rise in the same cycle as a completing S_WREN: the pixel is emitted and FRAME_SHORT also pulses. If that pixel is the EOF pixel, FRAME_SHORT is suppressed.
  - DONE: ignore S_WREN. Go to IDLE on a CON_ZERO rise, with no FRAME_SHORT.
- S_WREN in IDLE or DONE is ignored.
- ERR_CNT increments on each WORD_ERR pixel and saturates at 2^ERR_W-1. It holds after the frame until the next frame start.
- Pixels with WORD_ERR are still emitted. Position counters advance regardless, so the frame geometry is preserved.
- Arithmetic:
  - Column counter is clog2(COLS) bits; row counter is clog2(ROWS) bits.
  - Wrap by compare to COLS-1 / ROWS-1, never by natural overflow.

## Timing
- Latency: PIX_VALID and all qualifiers are asserted the cycle after the S_WREN that carries the stop bit (registered outputs).
- PIX_DATA holds its value until the next PIX_VALID.
- PIX_VALID is never asserted on consecutive cycles unless S_WREN is. No throughput limit beyond one bit per cycle.
- CON_ZERO edge detection costs one cycle:
  - The first S_WREN accepted after a CON_ZERO fall is the one at least one cycle after the fall.
  - An S_WREN in the same cycle as the fall is ignored.
- FRAME_SHORT is asserted one cycle after the CON_ZERO rise is detected.
- Asynchronous RESET mid-frame: all state returns to IDLE immediately and the outputs go to 0. The next frame start requires a fresh CON_ZERO fall.

## Structure
- Shared package nan_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - NAN_COLS=250, NAN_ROWS=250, NAN_WORD_W=12;
  - start/stop bit constants (START_BIT=1, STOP_BIT=0).
- One natural sub-module: nan_pos_counter, the column/row counter with SOL/EOL/SOF/EOF decode, reusable by the line-buffer writer.
- Shift register, bit counter and FSM stay in the top.

## Test plan
- Nominal small frame (COLS=4, ROWS=3): CON_ZERO fall, then 12 words of pattern 1_<pix>_0 with pix=0x155, 0x2AA, … -> 12 PIX_VALID.
  - SOF on word 0, SOL/EOL every 4, EOF on word 11.
  - Then DONE, ERR_CNT=0.
- Bad framing: word 5 sent with start=0, word 7 with stop=1 -> WORD_ERR on exactly those pixels, ERR_CNT=2, PIX_DATA still correct.
- Truncated frame: CON_ZERO rises after 6 words plus 5 bits -> 6 PIX_VALID, FRAME_SHORT pulse, FSM in IDLE. The next frame restarts at SOF.
- Sparse strobes: S_WREN every 1, 3 and 7 cycles, and S_WREN in the same cycle as the CON_ZERO fall -> that bit is ignored. Pixel values match, latency is exactly 1 cycle after the stop-bit S_WREN.
- Reset mid-frame: RESET low during word 3 -> all outputs 0. Then S_WREN without a CON_ZERO fall -> no PIX_VALID.
- ERR_CNT saturation (ERR_W=2): 5 bad words -> ERR_CNT=3 holds. Cleared to 0 at the next frame start.

Source files
------------

// File: rtl/nan_pkg.sv
// ---------------------------------------------------------------------------
// nan_pkg
// Shared definitions for the NanEye pixel path: deserializer FSM states,
// default sensor geometry, serial word length and the framing bit values.
// No ports; imported by nan_pixel_deser and nan_pos_counter.
// ---------------------------------------------------------------------------
package nan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } nan_state_e;

   localparam int NAN_COLS   = 250;
   localparam int NAN_ROWS   = 250;
   localparam int NAN_WORD_W = 12;

   localparam logic START_BIT = 1'b1;
   localparam logic STOP_BIT  = 1'b0;

   // A word is malformed when either framing bit has the wrong level.
   function automatic logic framing_bad(input logic start_b, input logic stop_b);
      return (start_b != START_BIT) || (stop_b != STOP_BIT);
   endfunction

endpackage

// File: rtl/nan_pos_counter.sv
// ---------------------------------------------------------------------------
// nan_pos_counter
// Column/row position tracker for a COLS x ROWS frame with start/end of line
// and start/end of frame decode of the *current* position.
//
// Ports:
//   SCLOCK  in   clock
//   RESET   in   asynchronous active-low reset
//   clr_i   in   return to row 0, column 0 (has priority over adv_i)
//   adv_i   in   step to the next pixel position
//   sol_o   out  current column is 0
//   eol_o   out  current column is COLS-1
//   sof_o   out  current position is row 0, column 0
//   eof_o   out  current position is row ROWS-1, column COLS-1
// ---------------------------------------------------------------------------
module nan_pos_counter
   import nan_pkg::*;
#(
   parameter int COLS = NAN_COLS,
   parameter int ROWS = NAN_ROWS
) (
   input  logic SCLOCK,
   input  logic RESET,
   input  logic clr_i,
   input  logic adv_i,
   output logic sol_o,
   output logic eol_o,
   output logic sof_o,
   output logic eof_o
);

   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   // Wrap by explicit compare: COLS/ROWS are generally not powers of two.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (adv_i) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge SCLOCK or negedge RESET) begin
      if (!RESET) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign sol_o = (col_q == '0);
   assign eol_o = (col_q == COL_LAST);
   assign sof_o = sol_o && (row_q == '0);
   assign eof_o = eol_o && (row_q == ROW_LAST);

endmodule

// File: rtl/nan_pixel_deser.sv
// ---------------------------------------------------------------------------
// nan_pixel_deser
// Frames the decoded NanEye bit stream into WORD_W-bit words (start bit,
// PIX_W pixel bits MSB first, stop bit), checks the framing bits and tags
// each pixel with line/frame position markers.
//
// Stream semantics: S_WREN is a one-cycle qualifier for S_DATA with no
// backpressure; PIX_VALID is a one-cycle strobe with no backpressure, and
// PIX_DATA/PIX_SOL/PIX_EOL/PIX_SOF/PIX_EOF/WORD_ERR are meaningful only
// while it is high. All outputs are registered.
//
// Ports:
//   SCLOCK       in   sampling clock (decoder domain)
//   RESET        in   asynchronous active-low reset
//   S_DATA       in   decoded bit, qualified by S_WREN
//   S_WREN       in   one-cycle bit strobe
//   CON_ZERO     in   sync/idle gap indicator; falling edge starts a frame
//   PIX_DATA     out  last assembled pixel (held between strobes)
//   PIX_VALID    out  pixel strobe, one cycle after the stop-bit strobe
//   PIX_SOL      out  pixel is column 0
//   PIX_EOL      out  pixel is column COLS-1
//   PIX_SOF      out  pixel is row 0, column 0
//   PIX_EOF      out  pixel is row ROWS-1, column COLS-1
//   WORD_ERR     out  pixel had a bad start or stop bit
//   FRAME_SHORT  out  pulse: gap began before the frame completed
//   ERR_CNT      out  saturating WORD_ERR count for the current frame
//   dbg_state_o  out  current FSM state
// ---------------------------------------------------------------------------
module nan_pixel_deser
   import nan_pkg::*;
#(
   parameter int WORD_W = NAN_WORD_W,
   parameter int PIX_W  = WORD_W - 2,
   parameter int COLS   = NAN_COLS,
   parameter int ROWS   = NAN_ROWS,
   parameter int ERR_W  = 8
) (
   input  logic             SCLOCK,
   input  logic             RESET,
   input  logic             S_DATA,
   input  logic             S_WREN,
   input  logic             CON_ZERO,
   output logic [PIX_W-1:0] PIX_DATA,
   output logic             PIX_VALID,
   output logic             PIX_SOL,
   output logic             PIX_EOL,
   output logic             PIX_SOF,
   output logic             PIX_EOF,
   output logic             WORD_ERR,
   output logic             FRAME_SHORT,
   output logic [ERR_W-1:0] ERR_CNT,
   output nan_state_e       dbg_state_o
);

   localparam int BCW = $clog2(WORD_W);
   localparam logic [BCW-1:0]   BIT_LAST = BCW'(WORD_W - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   nan_state_e       state_q, state_d;
   logic             cz_q;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   // Holds the WORD_W-1 bits received so far; the final bit of a word is
   // taken straight from S_DATA when it completes.
   logic [WORD_W-2:0] shreg_q, shreg_d;
   logic [PIX_W-1:0] pix_data_q, pix_data_d;
   logic             pix_valid_q, pix_valid_d;
   logic             pix_sol_q, pix_sol_d;
   logic             pix_eol_q, pix_eol_d;
   logic             pix_sof_q, pix_sof_d;
   logic             pix_eof_q, pix_eof_d;
   logic             word_err_q, word_err_d;
   logic             frame_short_q, frame_short_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic              cz_rise, cz_fall;
   logic [WORD_W-1:0] word_full;
   logic              word_done;
   logic              word_bad;
   logic              pos_clr, pos_adv;
   logic              pos_sol, pos_eol, pos_sof, pos_eof;

   assign cz_rise   = CON_ZERO && !cz_q;
   assign cz_fall   = !CON_ZERO && cz_q;
   assign word_full = {shreg_q, S_DATA};
   assign word_bad  = framing_bad(word_full[WORD_W-1], word_full[0]);

   nan_pos_counter #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_pos (
      .SCLOCK (SCLOCK),
      .RESET  (RESET),
      .clr_i  (pos_clr),
      .adv_i  (pos_adv),
      .sol_o  (pos_sol),
      .eol_o  (pos_eol),
      .sof_o  (pos_sof),
      .eof_o  (pos_eof)
   );

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shreg_d       = shreg_q;
      pix_data_d    = pix_data_q;
      pix_valid_d   = 1'b0;
      pix_sol_d     = 1'b0;
      pix_eol_d     = 1'b0;
      pix_sof_d     = 1'b0;
      pix_eof_d     = 1'b0;
      word_err_d    = 1'b0;
      frame_short_d = 1'b0;
      err_cnt_d     = err_cnt_q;
      pos_clr       = 1'b0;
      pos_adv       = 1'b0;
      word_done     = 1'b0;

      unique case (state_q)
         IDLE: begin
            // S_WREN coinciding with the fall is dropped: we are still in IDLE.
            if (cz_fall) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
               shreg_d   = '0;
               err_cnt_d = '0;
               pos_clr   = 1'b1;
            end
         end

         SHIFT: begin
            if (S_WREN) begin
               shreg_d = word_full[WORD_W-2:0];
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
                  word_done = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end

            if (word_done) begin
               pix_valid_d = 1'b1;
               pix_data_d  = word_full[WORD_W-2:1];
               pix_sol_d   = pos_sol;
               pix_eol_d   = pos_eol;
               pix_sof_d   = pos_sof;
               pix_eof_d   = pos_eof;
               word_err_d  = word_bad;
               pos_adv     = 1'b1;
               if (word_bad && (err_cnt_q != ERR_MAX)) begin
                  err_cnt_d = err_cnt_q + 1'b1;
               end
               if (pos_eof) begin
                  state_d = DONE;
               end
            end

            // A gap that lands on the EOF stop bit is a normal frame end.
            if (cz_rise) begin
               state_d       = IDLE;
               frame_short_d = !(word_done && pos_eof);
            end
         end

         DONE: begin
            if (cz_rise) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge SCLOCK or negedge RESET) begin
      if (!RESET) begin
         state_q       <= IDLE;
         cz_q          <= 1'b0;
         bit_cnt_q     <= '0;
         shreg_q       <= '0;
         pix_data_q    <= '0;
         pix_valid_q   <= 1'b0;
         pix_sol_q     <= 1'b0;
         pix_eol_q     <= 1'b0;
         pix_sof_q     <= 1'b0;
         pix_eof_q     <= 1'b0;
         word_err_q    <= 1'b0;
         frame_short_q <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         cz_q          <= CON_ZERO;
         bit_cnt_q     <= bit_cnt_d;
         shreg_q       <= shreg_d;
         pix_data_q    <= pix_data_d;
         pix_valid_q   <= pix_valid_d;
         pix_sol_q     <= pix_sol_d;
         pix_eol_q     <= pix_eol_d;
         pix_sof_q     <= pix_sof_d;
         pix_eof_q     <= pix_eof_d;
         word_err_q    <= word_err_d;
         frame_short_q <= frame_short_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign PIX_DATA    = pix_data_q;
   assign PIX_VALID   = pix_valid_q;
   assign PIX_SOL     = pix_sol_q;
   assign PIX_EOL     = pix_eol_q;
   assign PIX_SOF     = pix_sof_q;
   assign PIX_EOF     = pix_eof_q;
   assign WORD_ERR    = word_err_q;
   assign FRAME_SHORT = frame_short_q;
   assign ERR_CNT     = err_cnt_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nan_pixel_deser.sv
module tb_nan_pixel_deser;
   import nan_pkg::*;

   localparam int COLS = 4;
   localparam int ROWS = 3;
   localparam int NW   = COLS * ROWS;

   logic       SCLOCK   = 1'b0;
   logic       RESET    = 1'b0;
   logic       S_DATA   = 1'b0;
   logic       S_WREN   = 1'b0;
   logic       CON_ZERO = 1'b1;
   logic [9:0] PIX_DATA;
   logic       PIX_VALID, PIX_SOL, PIX_EOL, PIX_SOF, PIX_EOF, WORD_ERR, FRAME_SHORT;
   logic [1:0] ERR_CNT;
   nan_state_e dbg_state;

   int total = 0;
   int bad   = 0;

   // captured at the sample following a word's stop-bit strobe
   int         cap_stray;
   logic       cap_valid, cap_err, cap_fs;
   logic [9:0] cap_data;
   logic [3:0] cap_flags;
   logic [1:0] cap_cnt;

   logic [9:0] pix_tab [NW] = '{10'h155, 10'h2AA, 10'h001, 10'h200, 10'h3FF, 10'h000,
                                10'h123, 10'h2DC, 10'h0F0, 10'h30F, 10'h1A5, 10'h05A};

   nan_pixel_deser #(
      .WORD_W (12),
      .PIX_W  (10),
      .COLS   (COLS),
      .ROWS   (ROWS),
      .ERR_W  (2)
   ) dut (
      .SCLOCK      (SCLOCK),
      .RESET       (RESET),
      .S_DATA      (S_DATA),
      .S_WREN      (S_WREN),
      .CON_ZERO    (CON_ZERO),
      .PIX_DATA    (PIX_DATA),
      .PIX_VALID   (PIX_VALID),
      .PIX_SOL     (PIX_SOL),
      .PIX_EOL     (PIX_EOL),
      .PIX_SOF     (PIX_SOF),
      .PIX_EOF     (PIX_EOF),
      .WORD_ERR    (WORD_ERR),
      .FRAME_SHORT (FRAME_SHORT),
      .ERR_CNT     (ERR_CNT),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 SCLOCK = ~SCLOCK;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge SCLOCK);
      #1;
   endtask

   // {sol, eol, sof, eof} expected for word index k of the 4x3 frame
   function automatic logic [3:0] exp_flags(input int k);
      return {(k % COLS) == 0, (k % COLS) == COLS - 1, k == 0, k == NW - 1};
   endfunction

   // Idle gap of two cycles, then a CON_ZERO fall; optionally strobe a '1'
   // bit in the fall cycle (must be ignored by the DUT).
   task automatic frame_start(input logic wren_at_fall);
      CON_ZERO = 1'b1;
      tick();
      tick();
      CON_ZERO = 1'b0;
      S_WREN   = wren_at_fall;
      S_DATA   = 1'b1;
      tick();
      S_WREN   = 1'b0;
   endtask

   // Send one 12-bit word MSB first, one strobe every 'gap' cycles.
   task automatic send_word(input logic [11:0] w, input int gap, input logic rise_last);
      cap_stray = 0;
      for (int i = 0; i < 12; i++) begin
         S_WREN = 1'b1;
         S_DATA = w[11-i];
         if (i == 11 && rise_last) CON_ZERO = 1'b1;
         tick();
         if (i == 11) begin
            cap_valid = PIX_VALID;
            cap_data  = PIX_DATA;
            cap_flags = {PIX_SOL, PIX_EOL, PIX_SOF, PIX_EOF};
            cap_err   = WORD_ERR;
            cap_cnt   = ERR_CNT;
            cap_fs    = FRAME_SHORT;
         end else if (PIX_VALID) begin
            cap_stray++;
         end
         S_WREN = 1'b0;
         S_DATA = 1'($urandom_range(0, 1));
         for (int g = 1; g < gap; g++) begin
            tick();
            if (PIX_VALID) cap_stray++;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RESET = 1'b0;
      tick();
      tick();
      total++;
      if ({PIX_DATA, PIX_VALID, PIX_SOL, PIX_EOL, PIX_SOF, PIX_EOF, WORD_ERR, FRAME_SHORT, ERR_CNT} !== '0) begin
         $display("FAIL reset_outputs: got data=%0h valid=%0b cnt=%0d want all zero", PIX_DATA, PIX_VALID, ERR_CNT);
         bad++;
      end
      total++;
      if (dbg_state !== IDLE) begin
         $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
         bad++;
      end
      RESET = 1'b1;
      tick();
   endtask

   task automatic test_nominal();
      frame_start(1'b0);
      total++;
      if (dbg_state !== SHIFT) begin
         $display("FAIL nominal_enter_shift: got %0d want %0d", dbg_state, SHIFT);
         bad++;
      end
      for (int k = 0; k < NW; k++) begin
         send_word({1'b1, pix_tab[k], 1'b0}, 1, 1'b0);
         total++;
         if (cap_valid !== 1'b1 || cap_stray !== 0) begin
            $display("FAIL nominal_valid[%0d]: got valid=%0b stray=%0d want 1/0", k, cap_valid, cap_stray);
            bad++;
         end
         total++;
         if (cap_data !== pix_tab[k]) begin
            $display("FAIL nominal_data[%0d]: got %0h want %0h", k, cap_data, pix_tab[k]);
            bad++;
         end
         total++;
         if (cap_flags !== exp_flags(k)) begin
            $display("FAIL nominal_flags[%0d]: got %b want %b", k, cap_flags, exp_flags(k));
            bad++;
         end
         total++;
         if (cap_err !== 1'b0 || cap_cnt !== 2'd0 || cap_fs !== 1'b0) begin
            $display("FAIL nominal_err[%0d]: got err=%0b cnt=%0d fs=%0b want 0/0/0", k, cap_err, cap_cnt, cap_fs);
            bad++;
         end
      end
      total++;
      if (dbg_state !== DONE || ERR_CNT !== 2'd0) begin
         $display("FAIL nominal_done: got state=%0d cnt=%0d want %0d/0", dbg_state, ERR_CNT, DONE);
         bad++;
      end
      // strobes in DONE are ignored
      send_word({1'b1, 10'h155, 1'b0}, 1, 1'b0);
      total++;
      if (cap_valid !== 1'b0 || cap_stray !== 0) begin
         $display("FAIL done_ignores_wren: got valid=%0b stray=%0d want 0/0", cap_valid, cap_stray);
         bad++;
      end
      CON_ZERO = 1'b1;
      tick();
      total++;
      if (FRAME_SHORT !== 1'b0 || dbg_state !== IDLE) begin
         $display("FAIL done_to_idle: got fs=%0b state=%0d want 0/%0d", FRAME_SHORT, dbg_state, IDLE);
         bad++;
      end
   endtask

   task automatic test_bad_framing();
      logic [11:0] w;
      logic        e_err;
      logic [1:0]  e_cnt;
      frame_start(1'b0);
      for (int k = 0; k < NW; k++) begin
         w = {1'b1, pix_tab[k], 1'b0};
         if (k == 5) w[11] = 1'b0;
         if (k == 7) w[0]  = 1'b1;
         e_err = (k == 5) || (k == 7);
         e_cnt = (k >= 7) ? 2'd2 : (k >= 5) ? 2'd1 : 2'd0;
         send_word(w, 1, 1'b0);
         total++;
         if (cap_valid !== 1'b1 || cap_data !== pix_tab[k]) begin
            $display("FAIL badfr_data[%0d]: got valid=%0b data=%0h want 1/%0h", k, cap_valid, cap_data, pix_tab[k]);
            bad++;
         end
         total++;
         if (cap_err !== e_err || cap_cnt !== e_cnt) begin
            $display("FAIL badfr_err[%0d]: got err=%0b cnt=%0d want %0b/%0d", k, cap_err, cap_cnt, e_err, e_cnt);
            bad++;
         end
         total++;
         if (cap_flags !== exp_flags(k)) begin
            $display("FAIL badfr_flags[%0d]: got %b want %b", k, cap_flags, exp_flags(k));
            bad++;
         end
      end
      total++;
      if (ERR_CNT !== 2'd2 || dbg_state !== DONE) begin
         $display("FAIL badfr_final: got cnt=%0d state=%0d want 2/%0d", ERR_CNT, dbg_state, DONE);
         bad++;
      end
      CON_ZERO = 1'b1;
      tick();
   endtask

   task automatic test_truncated();
      int n_valid;
      int n_stray;
      n_valid = 0;
      n_stray = 0;
      frame_start(1'b0);
      for (int k = 0; k < 6; k++) begin
         send_word({1'b1, pix_tab[k], 1'b0}, 1, 1'b0);
         if (cap_valid) n_valid++;
         n_stray += cap_stray;
      end
      for (int i = 0; i < 5; i++) begin
         S_WREN = 1'b1;
         S_DATA = 1'b1;
         tick();
         if (PIX_VALID) n_stray++;
      end
      S_WREN   = 1'b0;
      CON_ZERO = 1'b1;
      tick();
      total++;
      if (n_valid !== 6 || n_stray !== 0) begin
         $display("FAIL trunc_count: got valid=%0d stray=%0d want 6/0", n_valid, n_stray);
         bad++;
      end
      total++;
      if (FRAME_SHORT !== 1'b1 || PIX_VALID !== 1'b0 || dbg_state !== IDLE) begin
         $display("FAIL trunc_short: got fs=%0b valid=%0b state=%0d want 1/0/%0d", FRAME_SHORT, PIX_VALID, dbg_state, IDLE);
         bad++;
      end
      tick();
      total++;
      if (FRAME_SHORT !== 1'b0) begin
         $display("FAIL trunc_pulse_width: got fs=%0b want 0", FRAME_SHORT);
         bad++;
      end
      // next frame restarts at SOF
      frame_start(1'b0);
      send_word({1'b1, 10'h3C3, 1'b0}, 1, 1'b0);
      total++;
      if (cap_valid !== 1'b1 || cap_flags !== exp_flags(0) || cap_data !== 10'h3C3) begin
         $display("FAIL trunc_restart_sof: got valid=%0b flags=%b data=%0h want 1/%b/3c3", cap_valid, cap_flags, cap_data, exp_flags(0));
         bad++;
      end
      CON_ZERO = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_short_collision();
      // non-EOF word completes in the rise cycle: pixel plus FRAME_SHORT
      frame_start(1'b0);
      send_word({1'b1, pix_tab[0], 1'b0}, 1, 1'b0);
      send_word({1'b1, pix_tab[1], 1'b0}, 1, 1'b0);
      send_word({1'b1, pix_tab[2], 1'b0}, 1, 1'b1);
      total++;
      if (cap_valid !== 1'b1 || cap_fs !== 1'b1 || cap_data !== pix_tab[2] || cap_flags !== exp_flags(2)) begin
         $display("FAIL collide_mid: got valid=%0b fs=%0b data=%0h flags=%b want 1/1/%0h/%b",
                  cap_valid, cap_fs, cap_data, cap_flags, pix_tab[2], exp_flags(2));
         bad++;
      end
      total++;
      if (dbg_state !== IDLE) begin
         $display("FAIL collide_mid_state: got %0d want %0d", dbg_state, IDLE);
         bad++;
      end
      tick();
      // EOF word completes in the rise cycle: no FRAME_SHORT
      frame_start(1'b0);
      for (int k = 0; k < NW - 1; k++) send_word({1'b1, pix_tab[k], 1'b0}, 1, 1'b0);
      send_word({1'b1, pix_tab[NW-1], 1'b0}, 1, 1'b1);
      total++;
      if (cap_valid !== 1'b1 || cap_fs !== 1'b0 || cap_flags !== exp_flags(NW - 1)) begin
         $display("FAIL collide_eof: got valid=%0b fs=%0b flags=%b want 1/0/%b", cap_valid, cap_fs, cap_flags, exp_flags(NW - 1));
         bad++;
      end
      tick();
      total++;
      if (dbg_state !== IDLE || FRAME_SHORT !== 1'b0) begin
         $display("FAIL collide_eof_after: got state=%0d fs=%0b want %0d/0", dbg_state, FRAME_SHORT, IDLE);
         bad++;
      end
   endtask

   task automatic test_sparse();
      int gap;
      frame_start(1'b1);   // strobe in the fall cycle must be dropped
      for (int k = 0; k < NW; k++) begin
         gap = ((k % 3) == 0) ? 1 : ((k % 3) == 1) ? 3 : 7;
         send_word({1'b1, pix_tab[k], 1'b0}, gap, 1'b0);
         total++;
         if (cap_valid !== 1'b1 || cap_stray !== 0 || cap_data !== pix_tab[k]) begin
            $display("FAIL sparse[%0d]: got valid=%0b stray=%0d data=%0h want 1/0/%0h",
                     k, cap_valid, cap_stray, cap_data, pix_tab[k]);
            bad++;
         end
      end
      total++;
      if (dbg_state !== DONE || ERR_CNT !== 2'd0) begin
         $display("FAIL sparse_done: got state=%0d cnt=%0d want %0d/0", dbg_state, ERR_CNT, DONE);
         bad++;
      end
      CON_ZERO = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      frame_start(1'b0);
      send_word({1'b1, 10'h111, 1'b0}, 1, 1'b0);
      send_word({1'b0, 10'h222, 1'b0}, 1, 1'b0);
      send_word({1'b1, 10'h2C3, 1'b0}, 1, 1'b0);
      total++;
      if (PIX_DATA !== 10'h2C3 || ERR_CNT !== 2'd1) begin
         $display("FAIL rstmid_pre: got data=%0h cnt=%0d want 2c3/1", PIX_DATA, ERR_CNT);
         bad++;
      end
      for (int i = 0; i < 6; i++) begin
         S_WREN = 1'b1;
         S_DATA = 1'b1;
         tick();
      end
      S_WREN = 1'b0;
      #2;
      RESET = 1'b0;
      #1;
      total++;
      if ({PIX_DATA, PIX_VALID, PIX_SOL, PIX_EOL, PIX_SOF, PIX_EOF, WORD_ERR, FRAME_SHORT, ERR_CNT} !== '0) begin
         $display("FAIL rstmid_outputs: got data=%0h cnt=%0d want 0/0", PIX_DATA, ERR_CNT);
         bad++;
      end
      total++;
      if (dbg_state !== IDLE) begin
         $display("FAIL rstmid_state: got %0d want %0d", dbg_state, IDLE);
         bad++;
      end
      tick();
      tick();
      RESET = 1'b1;
      tick();
      // CON_ZERO stays low: no fresh fall, so no frame
      send_word({1'b1, 10'h155, 1'b0}, 1, 1'b0);
      send_word({1'b1, 10'h2AA, 1'b0}, 1, 1'b0);
      total++;
      if (cap_valid !== 1'b0 || cap_stray !== 0 || dbg_state !== IDLE) begin
         $display("FAIL rstmid_no_frame: got valid=%0b stray=%0d state=%0d want 0/0/%0d", cap_valid, cap_stray, dbg_state, IDLE);
         bad++;
      end
   endtask

   task automatic test_err_sat();
      logic [11:0] w;
      logic [1:0]  e_cnt;
      frame_start(1'b0);
      for (int k = 0; k < NW; k++) begin
         w = {1'b1, pix_tab[k], 1'b0};
         if (k < 5 && (k % 2) == 0) w[11] = 1'b0;
         if (k < 5 && (k % 2) == 1) w[0]  = 1'b1;
         e_cnt = (k >= 2) ? 2'd3 : 2'(k + 1);
         send_word(w, 1, 1'b0);
         total++;
         if (cap_err !== (k < 5) || cap_cnt !== e_cnt) begin
            $display("FAIL sat[%0d]: got err=%0b cnt=%0d want %0b/%0d", k, cap_err, cap_cnt, k < 5, e_cnt);
            bad++;
         end
      end
      CON_ZERO = 1'b1;
      tick();
      tick();
      total++;
      if (ERR_CNT !== 2'd3 || dbg_state !== IDLE) begin
         $display("FAIL sat_hold: got cnt=%0d state=%0d want 3/%0d", ERR_CNT, dbg_state, IDLE);
         bad++;
      end
      frame_start(1'b0);
      total++;
      if (ERR_CNT !== 2'd0) begin
         $display("FAIL sat_clear: got %0d want 0", ERR_CNT);
         bad++;
      end
      CON_ZERO = 1'b1;
      tick();
      tick();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_nominal();
      test_bad_framing();
      test_truncated();
      test_short_collision();
      test_sparse();
      test_reset_mid();
      test_err_sat();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
